// File: rtl/wb_write_queue.sv
// Writeback queue: buffers {rd, data} requests, drains one per granted cycle into the
// register-file write port and forwards pending data to two read lookups.
// Optional zero-latency empty-queue bypass is enabled by defining WB_BYPASS_EN.
module wb_write_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rd,
  input  logic [63:0]      in_data,
  input  logic             wr_grant,
  output logic             RegWrite,
  output logic [4:0]       RD,
  output logic [63:0]      WriteData,
  input  logic [4:0]       RS1,
  input  logic [4:0]       RS2,
  output logic             fwd1_hit,
  output logic [63:0]      fwd1_data,
  output logic             fwd2_hit,
  output logic [63:0]      fwd2_data,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [4:0]       rd_q   [DEPTH];
  logic [4:0]       rd_d   [DEPTH];
  logic [63:0]      data_q [DEPTH];
  logic [63:0]      data_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic not_empty_c;
  logic bypass_c;
  logic push_c;
  logic pop_c;

  assign not_empty_c = (count_q != '0);
  assign in_ready    = (count_q < CNT_W'(DEPTH));
  assign pop_c       = not_empty_c && wr_grant;

`ifdef WB_BYPASS_EN
  assign bypass_c = !not_empty_c && wr_grant && in_valid && (in_rd != 5'd0);
`else
  assign bypass_c = 1'b0;
`endif

  // x0 writes complete the handshake but are dropped; bypassed writes never enter the queue
  assign push_c = in_valid && in_ready && (in_rd != 5'd0) && !bypass_c;

  assign count = count_q;

  // Write-port drive: head entry when non-empty, in-flight request when bypassing
  always_comb begin
    RegWrite  = pop_c || bypass_c;
    RD        = 5'd0;
    WriteData = 64'd0;
    if (not_empty_c) begin
      RD        = rd_q[head_q];
      WriteData = data_q[head_q];
    end else if (bypass_c) begin
      RD        = in_rd;
      WriteData = in_data;
    end
  end

  // Forwarding: scan oldest to youngest so the youngest match overwrites older ones
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd1_hit  = 1'b0;
    fwd1_data = 64'd0;
    fwd2_hit  = 1'b0;
    fwd2_data = 64'd0;
    idx       = head_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (vld_q[idx] && (rd_q[idx] == RS1) && (RS1 != 5'd0)) begin
        fwd1_hit  = 1'b1;
        fwd1_data = data_q[idx];
      end
      if (vld_q[idx] && (rd_q[idx] == RS2) && (RS2 != 5'd0)) begin
        fwd2_hit  = 1'b1;
        fwd2_data = data_q[idx];
      end
    end
    if (bypass_c && (in_rd == RS1)) begin
      fwd1_hit  = 1'b1;
      fwd1_data = in_data;
    end
    if (bypass_c && (in_rd == RS2)) begin
      fwd2_hit  = 1'b1;
      fwd2_data = in_data;
    end
  end

  // Next-state for storage, pointers and occupancy
  always_comb begin
    rd_d    = rd_q;
    data_d  = data_q;
    vld_d   = vld_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_c) begin
      vld_d[head_q] = 1'b0;
      head_d        = head_q + PTR_W'(1);
    end
    if (push_c) begin
      rd_d[tail_q]   = in_rd;
      data_d[tail_q] = in_data;
      vld_d[tail_q]  = 1'b1;
      tail_d         = tail_q + PTR_W'(1);
    end
    if (push_c && !pop_c) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_c && !push_c) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= 5'd0;
        data_q[i] <= 64'd0;
      end
      vld_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed self-checking bench for wb_write_queue (default build, bypass disabled).
module tb_wb_write_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [63:0] in_data;
  logic        wr_grant;
  logic        RegWrite;
  logic [4:0]  RD;
  logic [63:0] WriteData;
  logic [4:0]  RS1;
  logic [4:0]  RS2;
  logic        fwd1_hit;
  logic [63:0] fwd1_data;
  logic        fwd2_hit;
  logic [63:0] fwd2_data;
  logic [2:0]  count;

  int n_assert = 0;
  int n_fail   = 0;

  wb_write_queue #(.DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
    .wr_grant(wr_grant),
    .RegWrite(RegWrite), .RD(RD), .WriteData(WriteData),
    .RS1(RS1), .RS2(RS2),
    .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
    .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_rd = 5'd0; in_data = 64'd0;
    wr_grant = 1'b0; RS1 = 5'd0; RS2 = 5'd0;
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_regwrite", 64'(RegWrite), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_rd", 64'(RD), 64'd0);
    chk("rst_wdata", WriteData, 64'd0);
    chk("rst_fwd1_hit", 64'(fwd1_hit), 64'd0);
    chk("rst_fwd2_data", fwd2_data, 64'd0);
    #10 reset = 1'b0;
    step();

    // Single push with grant: written the cycle after acceptance
    in_valid = 1'b1; in_rd = 5'd5; in_data = 64'hDEAD_BEEF; wr_grant = 1'b1; RS1 = 5'd5;
    #1;
    chk("t1_no_same_cycle_write", 64'(RegWrite), 64'd0);
    chk("t1_no_fwd_before_push", 64'(fwd1_hit), 64'd0);
    step();
    in_valid = 1'b0;
    #1;
    chk("t1_regwrite", 64'(RegWrite), 64'd1);
    chk("t1_rd", 64'(RD), 64'd5);
    chk("t1_wdata", WriteData, 64'hDEAD_BEEF);
    chk("t1_count", 64'(count), 64'd1);
    chk("t1_fwd_during_pop", fwd1_data, 64'hDEAD_BEEF);
    step();
    chk("t1_count_after", 64'(count), 64'd0);
    chk("t1_regwrite_after", 64'(RegWrite), 64'd0);

    // Two writes to the same register: youngest forwards, drain is in order
    wr_grant = 1'b0; in_valid = 1'b1; in_rd = 5'd3; in_data = 64'h11;
    step();
    in_data = 64'h22;
    step();
    in_valid = 1'b0; RS1 = 5'd3;
    #1;
    chk("t2_fwd1_hit", 64'(fwd1_hit), 64'd1);
    chk("t2_fwd1_data", fwd1_data, 64'h22);
    chk("t2_count", 64'(count), 64'd2);
    chk("t2_no_write", 64'(RegWrite), 64'd0);
    wr_grant = 1'b1;
    #1;
    chk("t2_first_rw", 64'(RegWrite), 64'd1);
    chk("t2_first_rd", 64'(RD), 64'd3);
    chk("t2_first_data", WriteData, 64'h11);
    step();
    chk("t2_second_data", WriteData, 64'h22);
    chk("t2_count_mid", 64'(count), 64'd1);
    step();
    chk("t2_count_end", 64'(count), 64'd0);
    chk("t2_miss_hit", 64'(fwd1_hit), 64'd0);
    chk("t2_miss_data", fwd1_data, 64'd0);

    // Fill to full, hold a fifth request, free one slot, then drain across the wrap
    wr_grant = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_rd = 5'(i); in_data = 64'(100 + i);
      step();
    end
    in_rd = 5'd9; in_data = 64'h99; RS2 = 5'd9;
    #1;
    chk("t3_full_ready", 64'(in_ready), 64'd0);
    chk("t3_full_count", 64'(count), 64'd4);
    step();
    chk("t3_held_count", 64'(count), 64'd4);
    chk("t3_held_not_fwd", 64'(fwd2_hit), 64'd0);
    wr_grant = 1'b1;
    #1;
    chk("t3_pulse_rw", 64'(RegWrite), 64'd1);
    chk("t3_pulse_rd", 64'(RD), 64'd1);
    step();
    wr_grant = 1'b0;
    #1;
    chk("t3_ready_after_pop", 64'(in_ready), 64'd1);
    chk("t3_count_after_pop", 64'(count), 64'd3);
    step();
    in_valid = 1'b0; RS1 = 5'd2;
    #1;
    chk("t3_count_refill", 64'(count), 64'd4);
    chk("t3_fwd2_after_push", fwd2_data, 64'h99);
    chk("t3_fwd1_data", fwd1_data, 64'(102));
    wr_grant = 1'b1;
    begin
      logic [4:0] exp_rd [4];
      exp_rd[0] = 5'd2; exp_rd[1] = 5'd3; exp_rd[2] = 5'd4; exp_rd[3] = 5'd9;
      for (int i = 0; i < 4; i++) begin
        #1;
        chk("t3_drain_rd", 64'(RD), 64'(exp_rd[i]));
        step();
      end
    end
    chk("t3_drained", 64'(count), 64'd0);

    // x0 request: accepted, dropped, never forwarded
    in_valid = 1'b1; in_rd = 5'd0; in_data = 64'hFF; RS2 = 5'd0;
    #1;
    chk("t4_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    #1;
    chk("t4_count", 64'(count), 64'd0);
    chk("t4_no_write", 64'(RegWrite), 64'd0);
    chk("t4_fwd2_hit", 64'(fwd2_hit), 64'd0);

    // Continuous stream with grant: occupancy stays at one, order preserved through wraps
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_rd = 5'(10 + i); in_data = 64'(1000 + i);
      #1;
      chk("t5_count", 64'(count), (i == 0) ? 64'd0 : 64'd1);
      if (i > 0) begin
        chk("t5_rd", 64'(RD), 64'(10 + i - 1));
        chk("t5_data", WriteData, 64'(1000 + i - 1));
      end
      step();
    end
    in_valid = 1'b0;
    #1;
    chk("t5_last_rd", 64'(RD), 64'd19);
    step();
    chk("t5_empty", 64'(count), 64'd0);

    // Asynchronous reset mid-drain discards pending entries
    wr_grant = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_rd = 5'(11 + i); in_data = 64'(200 + i);
      step();
    end
    in_valid = 1'b0; wr_grant = 1'b1;
    #1;
    chk("t6_count_pre", 64'(count), 64'd3);
    chk("t6_rw_pre", 64'(RegWrite), 64'd1);
    reset = 1'b1;
    #1;
    chk("t6_rw_reset", 64'(RegWrite), 64'd0);
    chk("t6_count_reset", 64'(count), 64'd0);
    chk("t6_ready_reset", 64'(in_ready), 64'd1);
    chk("t6_rd_reset", 64'(RD), 64'd0);
    reset = 1'b0;
    in_valid = 1'b1; in_rd = 5'd7; in_data = 64'h77;
    step();
    in_valid = 1'b0;
    #1;
    chk("t6_new_rw", 64'(RegWrite), 64'd1);
    chk("t6_new_rd", 64'(RD), 64'd7);
    chk("t6_new_data", WriteData, 64'h77);
    chk("t6_new_count", 64'(count), 64'd1);
    step();
    chk("t6_final_count", 64'(count), 64'd0);
    chk("t6_final_rw", 64'(RegWrite), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
